// File: rtl/qeciphy_pkg.sv
// rtl/qeciphy_pkg.sv - Shared QECIPHY line characters, framing words and TX state type
package qeciphy_pkg;

  localparam logic [7:0]  K28_5     = 8'hBC;
  localparam logic [7:0]  K27_7     = 8'hFB;
  localparam logic [63:0] FAW_WORD  = 64'h4A4A_4A4A_4A4A_4ABC;
  localparam logic [7:0]  FAW_K     = 8'h01;
  localparam logic [63:0] IDLE_WORD = 64'h0000_0000_0000_00FB;
  localparam logic [7:0]  IDLE_K    = 8'h01;

  typedef enum logic [1:0] {
    TX_OFF,
    TX_IDLE,
    TX_ACTIVE
  } tx_state_t;

endpackage

// File: rtl/qeciphy_frame_counter.sv
// rtl/qeciphy_frame_counter.sv - Free-running frame slot counter with early FAW boundary strobe
module qeciphy_frame_counter #(
  parameter int FRAME_LEN = 64,
  parameter int CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [CW-1:0] slot_o,
  output logic          almost_faw_boundary_o
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_LEN - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_o <= '0;
    end else if (slot_o == LAST_SLOT) begin
      slot_o <= '0;
    end else begin
      slot_o <= slot_o + CW'(1);
    end
  end

  // Pure decode so the controller sees it in the same cycle the last slot is live.
  assign almost_faw_boundary_o = (slot_o == LAST_SLOT);

endmodule

// File: rtl/qeciphy_tx_packet_gen.sv
// rtl/qeciphy_tx_packet_gen.sv - TX framing: FAW insertion, idle fill and user data muxing
module qeciphy_tx_packet_gen
  import qeciphy_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int DATA_W    = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tx_off_i,
  input  logic                tx_idle_i,
  input  logic                tx_active_i,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic                almost_faw_boundary_o,
  output logic [DATA_W-1:0]   tx_data_o,
  output logic [DATA_W/8-1:0] tx_k_o
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int KW = DATA_W / 8;

  localparam logic [DATA_W-1:0] FAW_D  = DATA_W'(FAW_WORD);
  localparam logic [DATA_W-1:0] IDLE_D = DATA_W'(IDLE_WORD);
  localparam logic [KW-1:0]     FAW_KF = KW'(FAW_K);
  localparam logic [KW-1:0]     IDLE_KF = KW'(IDLE_K);

  logic [CW-1:0] slot;
  logic          faw_slot;
  tx_state_t     state;

  qeciphy_frame_counter #(
    .FRAME_LEN(FRAME_LEN),
    .CW       (CW)
  ) u_frame_counter (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .slot_o               (slot),
    .almost_faw_boundary_o(almost_faw_boundary_o)
  );

  // Off wins over everything; an all-zero pattern from the controller is also off.
  always_comb begin
    state = TX_OFF;
    if (tx_off_i || !(tx_idle_i || tx_active_i)) begin
      state = TX_OFF;
    end else if (tx_idle_i) begin
      state = TX_IDLE;
    end else begin
      state = TX_ACTIVE;
    end
  end

  assign faw_slot  = (slot == '0);
  assign s_ready_o = (state == TX_ACTIVE) && !faw_slot && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_data_o <= IDLE_D;
      tx_k_o    <= IDLE_KF;
    end else if (state == TX_OFF) begin
      tx_data_o <= IDLE_D;
      tx_k_o    <= IDLE_KF;
    end else if (faw_slot) begin
      tx_data_o <= FAW_D;
      tx_k_o    <= FAW_KF;
    end else if (s_ready_o && s_valid_i) begin
      tx_data_o <= s_data_i;
      tx_k_o    <= '0;
    end else begin
      tx_data_o <= IDLE_D;
      tx_k_o    <= IDLE_KF;
    end
  end

endmodule

// File: tb/tb_qeciphy_tx_packet_gen.sv
// tb/tb_qeciphy_tx_packet_gen.sv - Randomized self-checking bench for qeciphy_tx_packet_gen
module tb_qeciphy_tx_packet_gen;

  localparam int FL = 8;
  localparam logic [63:0] FAW_W  = 64'h4A4A_4A4A_4A4A_4ABC;
  localparam logic [63:0] IDLE_W = 64'h0000_0000_0000_00FB;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        tx_off_i = 1'b1, tx_idle_i = 1'b0, tx_active_i = 1'b0;
  logic [63:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o, almost_faw_boundary_o;
  logic [63:0] tx_data_o;
  logic [7:0]  tx_k_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;          // cycles since reset release; slot = cyc % FL
  int n_hs = 0;         // model handshakes
  int n_dw = 0;         // data words seen on the DUT output
  logic [63:0] exp_q[$];

  qeciphy_tx_packet_gen #(.FRAME_LEN(FL), .DATA_W(64)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .tx_off_i             (tx_off_i),
    .tx_idle_i            (tx_idle_i),
    .tx_active_i          (tx_active_i),
    .s_data_i             (s_data_i),
    .s_valid_i            (s_valid_i),
    .s_ready_o            (s_ready_o),
    .almost_faw_boundary_o(almost_faw_boundary_o),
    .tx_data_o            (tx_data_o),
    .tx_k_o               (tx_k_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // 0 = off, 1 = idle, 2 = active
  function automatic int eff_state(input logic [2:0] st);
    if (st[2] || st == 3'b000) return 0;
    if (st[1]) return 1;
    return 2;
  endfunction

  // Called at a negedge; applies inputs for one cycle and checks before/after the edge.
  task automatic step(input logic rst, input logic [2:0] st, input logic v,
                      input logic [63:0] d, output logic took);
    int s, slot;
    logic exp_rdy;
    logic [63:0] ew;
    logic [7:0] ek;
    rst_i = rst;
    {tx_off_i, tx_idle_i, tx_active_i} = st;
    s_valid_i = v;
    s_data_i = d;
    #1;
    s = eff_state(st);
    slot = cyc % FL;
    exp_rdy = (s == 2) && (slot != 0) && !rst;
    check("s_ready", {63'd0, s_ready_o}, {63'd0, exp_rdy});
    check("almost", {63'd0, almost_faw_boundary_o}, {63'd0, slot == FL - 1});
    took = exp_rdy && v;
    if (rst || s == 0)       begin ew = IDLE_W; ek = 8'h01; end
    else if (slot == 0)      begin ew = FAW_W;  ek = 8'h01; end
    else if (s == 1 || !v)   begin ew = IDLE_W; ek = 8'h01; end
    else                     begin ew = d;      ek = 8'h00; end
    if (took) begin exp_q.push_back(d); n_hs++; end
    @(posedge clk_i);
    #1;
    check("tx_data", tx_data_o, ew);
    check("tx_k", {56'd0, tx_k_o}, {56'd0, ek});
    if (tx_k_o == 8'h00) begin
      n_dw++;
      if (exp_q.size() == 0) check("order_underflow", 64'd1, 64'd0);
      else check("order", tx_data_o, exp_q.pop_front());
    end
    cyc = rst ? 0 : cyc + 1;
    @(negedge clk_i);
  endtask

  task automatic run(input int n, input logic [2:0] st, input int vmode);
    logic took;
    logic [63:0] nd;
    nd = 64'd1;
    for (int i = 0; i < n; i++) begin
      logic v;
      case (vmode)
        0: v = 1'b1;
        1: v = (i % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      step(1'b0, st, v, (vmode == 0 || vmode == 1) ? nd : {$urandom, $urandom}, took);
      if (took) nd++;
    end
  endtask

  task automatic align();
    logic took;
    int guard;
    guard = 0;
    while (cyc % FL != 0 && guard < FL) begin
      step(1'b0, 3'b100, 1'b0, '0, took);
      guard++;
    end
  endtask

  initial begin
    logic took;
    @(negedge clk_i);
    step(1'b1, 3'b100, 1'b1, 64'hDEAD, took);
    step(1'b1, 3'b001, 1'b1, 64'hBEEF, took);
    run(20, 3'b100, 2);                 // off
    align();
    run(16, 3'b010, 2);                 // idle
    run(24, 3'b001, 0);                 // active, continuous incrementing data
    run(24, 3'b001, 1);                 // active, valid toggling
    while (cyc % FL != 5) run(1, 3'b001, 2);
    step(1'b1, 3'b001, 1'b1, 64'h5555, took);   // reset mid-frame at slot 5
    run(10, 3'b001, 0);
    align();
    run(8, 3'b000, 2);                  // illegal all-zero
    run(8, 3'b101, 2);                  // off together with active
    run(8, 3'b111, 2);
    for (int f = 0; f < 40; f++) begin
      logic [2:0] st;
      st = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) step(1'b1, st, 1'b1, {$urandom, $urandom}, took);
      run(FL - (cyc % FL), st, 2);
    end
    check("handshake_count", 64'(n_dw), 64'(n_hs));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
